fwuart_rx: RTL and testbench

- UART receive path. Consumes the single-cycle 16x baud enable produced by the team's baud clock generator and oversamples the asynchronous rx line.
- Recovers 8N1-style frames (configurable data width, one stop bit, no parity) and presents each byte on a valid/ready stream.
- Reports framing errors and overruns as single-cycle pulses.
- Sits between the pad-side rx line and the UART register/FIFO logic, all in the system clock domain.

---
 rtl/fwuart_rx.sv | 142 ++++++++++++++
 tb/tb_fwuart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwuart_rx.sv
// UART receiver: 16x oversampled rx line, LSB-first frames with one stop bit,
// delivered on a valid/ready stream with framing-error and overrun pulses.
module fwuart_rx #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clock_x16,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dat_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int unsigned IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dat_q, dat_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic                 deliver;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        dat_d       = dat_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;

        if (clock_x16) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == IW'(DATA_BITS - 1)) begin
                            state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        // IDLE is re-entered at mid-stop so a back-to-back start bit is caught.
                        if (rx_s_q) begin
                            deliver = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (deliver) begin
            if (!valid_q || ready_i) begin
                dat_d   = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            dat_q       <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            dat_q       <= dat_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
        end
    end

    assign dat_o     = dat_q;
    assign valid_o   = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_fwuart_rx.sv
// Scoreboard bench for fwuart_rx: stimulus pushes expected events, monitors pop
// and compare on every accept, frame_err or overrun pulse.
module tb_fwuart_rx;
    localparam int K_DATA = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clock_x16 = 1'b0;
    logic       rx = 1'b1;
    logic       rx7 = 1'b1;
    logic       ready_i = 1'b1;
    logic       ready7 = 1'b1;
    logic [7:0] dat_o;
    logic [6:0] dat7;
    logic       valid_o, valid7;
    logic       frame_err, overrun, frame_err7, overrun7;

    int         tests = 0;
    int         fails = 0;
    logic [1:0] tick_div = 2'd0;

    ev_t        q[$];
    logic [6:0] q7[$];

    fwuart_rx #(.DATA_BITS(8)) dut (
        .clock(clock), .reset(reset), .clock_x16(clock_x16), .rx(rx),
        .dat_o(dat_o), .valid_o(valid_o), .ready_i(ready_i),
        .frame_err(frame_err), .overrun(overrun)
    );

    fwuart_rx #(.DATA_BITS(7)) dut7 (
        .clock(clock), .reset(reset), .clock_x16(clock_x16), .rx(rx7),
        .dat_o(dat7), .valid_o(valid7), .ready_i(ready7),
        .frame_err(frame_err7), .overrun(overrun7)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        tick_div  = tick_div + 2'd1;
        clock_x16 = (tick_div == 2'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clock);
            while (!clock_x16) @(posedge clock);
        end
        #1;
    endtask

    // Drives n bits LSB first, 16 ticks each, onto rx (sel=0) or rx7 (sel=1).
    task automatic drive_bits(input logic [15:0] bits, input int n, input bit sel);
        for (int i = 0; i < n; i++) begin
            if (sel) rx7 = bits[i];
            else     rx  = bits[i];
            wait_ticks(16);
        end
    endtask

    task automatic send(input logic [7:0] b);
        drive_bits({7'h7F, 1'b1, b, 1'b0}, 10, 1'b0);
    endtask

    // Main monitor: pops the scoreboard on each observable output event.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_dat = '0;

    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            ev_t e;
            if (prev_valid && !prev_ready) begin
                check("hold_valid", {31'd0, valid_o}, 32'd1);
                check("hold_dat", {24'd0, dat_o}, {24'd0, prev_dat});
            end
            if (frame_err && overrun) check("ferr_ovr_exclusive", 32'd1, 32'd0);
            if (valid_o && ready_i) begin
                if (q.size() == 0) check("unexpected_data", {24'd0, dat_o}, 32'hFFFF_FFFF);
                else begin
                    e = q.pop_front();
                    check("event_kind_data", K_DATA, e.kind);
                    check("data", {24'd0, dat_o}, {24'd0, e.data});
                end
            end
            if (frame_err) begin
                if (q.size() == 0) check("unexpected_frame_err", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    check("event_kind_ferr", K_FERR, e.kind);
                end
            end
            if (overrun) begin
                if (q.size() == 0) check("unexpected_overrun", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    check("event_kind_ovr", K_OVR, e.kind);
                end
            end
            prev_valid = valid_o;
            prev_ready = ready_i;
            prev_dat   = dat_o;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (frame_err7 || overrun7) check("dut7_err", 32'd1, 32'd0);
            if (valid7 && ready7) begin
                if (q7.size() == 0) check("dut7_unexpected", {25'd0, dat7}, 32'hFFFF_FFFF);
                else check("dut7_data", {25'd0, dat7}, {25'd0, q7.pop_front()});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_dat", {24'd0, dat_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        wait_ticks(8);

        // Basic frame
        push(K_DATA, 8'hA5);
        send(8'hA5);
        wait_ticks(8);

        // Start-bit glitch, then a real frame
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(24);
        push(K_DATA, 8'h3C);
        send(8'h3C);
        wait_ticks(8);

        // Framing error followed by a held-low break
        push(K_FERR, 8'h00);
        drive_bits({6'd0, 1'b0, 8'h3C, 1'b0}, 10, 1'b0);
        wait_ticks(40);
        rx = 1'b1;
        wait_ticks(20);
        push(K_DATA, 8'h81);
        send(8'h81);
        wait_ticks(8);

        // Overrun: second byte arrives while the first is held
        ready_i = 1'b0;
        push(K_OVR, 8'h00);
        push(K_DATA, 8'h11);
        send(8'h11);
        send(8'h22);
        wait_ticks(4);
        check("ovr_held_valid", {31'd0, valid_o}, 32'd1);
        check("ovr_held_dat", {24'd0, dat_o}, 32'h11);
        ready_i = 1'b1;
        @(posedge clock);
        #1;
        ready_i = 1'b0;
        check("ovr_accept_valid", {31'd0, valid_o}, 32'd0);
        check("ovr_accept_dat", {24'd0, dat_o}, 32'h11);
        ready_i = 1'b1;
        wait_ticks(8);

        // Back-to-back frames with no idle gap
        push(K_DATA, 8'h00);
        push(K_DATA, 8'hFF);
        push(K_DATA, 8'h55);
        send(8'h00);
        send(8'hFF);
        send(8'h55);
        wait_ticks(8);

        // Reset mid-frame while a byte is also held (held byte is lost)
        ready_i = 1'b0;
        send(8'h77);
        wait_ticks(4);
        check("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        drive_bits({7'd0, 8'hF0, 1'b0}, 5, 1'b0);
        rx = 1'b1;
        wait_ticks(8);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrst_dat", {24'd0, dat_o}, 32'd0);
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_ferr", {31'd0, frame_err}, 32'd0);
        check("midrst_ovr", {31'd0, overrun}, 32'd0);
        ready_i = 1'b1;
        wait_ticks(20);
        push(K_DATA, 8'h5A);
        send(8'h5A);
        wait_ticks(8);

        // Seven data bits
        q7.push_back(7'h25);
        drive_bits({7'h7F, 1'b1, 7'h25, 1'b0}, 9, 1'b1);
        wait_ticks(16);

        check("queue_drained", q.size(), 32'd0);
        check("queue7_drained", q7.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
